// File: rtl/time_keeper.sv
// time_keeper: BCD MM:SS.cc stopwatch/timer datapath with lap snapshots.
// Driven by the mode FSM strobes; feeds a 4-digit BCD word to the 7-seg decoder.
// Ports:
//   i_clk, i_nrst             clock, async active-low reset
//   i_clear                   sync clear (count, prescaler, laps, flags); top priority
//   i_enable                  run request
//   i_enable_increment/_decrement  direction; exactly one high to run
//   i_write / i_read          level inputs; rising edge stores lap / advances recall
//   i_output_select [1:0]     display source
//   i_load, i_preset [15:0]   load BCD MMSS preset (only while i_enable=0)
//   o_digits [15:0]           BCD display word
//   o_done, o_overflow        sticky down-count-complete / up-count-wrap flags
//   o_lap_count, o_lap_full   stored lap count, full indicator
module time_keeper #(
  parameter int TICK_DIV  = 100,
  parameter int LAP_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_nrst,
  input  logic                               i_clear,
  input  logic                               i_enable,
  input  logic                               i_enable_increment,
  input  logic                               i_enable_decrement,
  input  logic                               i_write,
  input  logic                               i_read,
  input  logic [1:0]                         i_output_select,
  input  logic                               i_load,
  input  logic [15:0]                        i_preset,
  output logic [15:0]                        o_digits,
  output logic                               o_done,
  output logic                               o_overflow,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     o_lap_count,
  output logic                               o_lap_full
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int LCW  = $clog2(LAP_DEPTH + 1);
  localparam int PTRW = $clog2(LAP_DEPTH);

  // Count packed as {m10,m1,s10,s1,c10,c1}; digit 3 (s10) and 5 (m10) roll at 5.
  function automatic logic [24:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        c;
    logic [3:0]  d;
    logic [3:0]  lim;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d   = v[i*4 +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (c) begin
        if (d >= lim) begin
          r[i*4 +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[i*4 +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = d;
      end
    end
    // Carry out of m10 means 59:59.99 wrapped to zero.
    return {c, r};
  endfunction

  // Returns {reached_zero, next}; zero input holds at zero.
  function automatic logic [24:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        b;
    logic [3:0]  d;
    logic [3:0]  lim;
    r = v;
    b = (v != 24'd0);
    for (int i = 0; i < 6; i++) begin
      d   = v[i*4 +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (b) begin
        if (d == 4'd0) begin
          r[i*4 +: 4] = lim;
          b = 1'b1;
        end else begin
          r[i*4 +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = d;
      end
    end
    return {(r == 24'd0), r};
  endfunction

  // Clamp tens digits to 5 and ones digits to 9.
  function automatic logic [15:0] sat_preset(input logic [15:0] p);
    logic [15:0] r;
    r[15:12] = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
    r[11:8]  = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    r[7:4]   = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    r[3:0]   = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return r;
  endfunction

  logic [23:0]     r_cnt;
  logic [PW-1:0]   r_pre;
  logic            r_done;
  logic            r_overflow;
  logic [23:0]     r_lap [LAP_DEPTH];
  logic [LCW-1:0]  r_lap_count;
  logic [PTRW-1:0] r_rd_ptr;
  logic            r_wr_hist;
  logic            r_rd_hist;

  logic            w_run;
  logic            w_tick;
  logic [24:0]     w_inc;
  logic [24:0]     w_dec;
  logic            w_wr_rise;
  logic            w_rd_rise;
  logic            w_lap_full;
  logic [LCW-1:0]  w_rd_ext;
  logic [23:0]     w_lap_sel;

  assign w_run      = i_enable & (i_enable_increment ^ i_enable_decrement);
  assign w_tick     = w_run & (r_pre == PW'(TICK_DIV - 1));
  assign w_inc      = bcd_inc(r_cnt);
  assign w_dec      = bcd_dec(r_cnt);
  assign w_wr_rise  = i_write & ~r_wr_hist;
  assign w_rd_rise  = i_read & ~r_rd_hist;
  assign w_lap_full = (r_lap_count == LCW'(LAP_DEPTH));
  assign w_rd_ext   = LCW'(r_rd_ptr) + LCW'(1);
  assign w_lap_sel  = r_lap[r_rd_ptr];

  // Time count, prescaler and sticky flags.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_cnt      <= 24'd0;
      r_pre      <= {PW{1'b0}};
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_cnt      <= 24'd0;
      r_pre      <= {PW{1'b0}};
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_load && !i_enable) begin
      r_cnt  <= {sat_preset(i_preset), 8'h00};
      r_pre  <= {PW{1'b0}};
      r_done <= 1'b0;
    end else if (w_tick) begin
      r_pre <= {PW{1'b0}};
      if (i_enable_increment) begin
        r_cnt <= w_inc[23:0];
        if (w_inc[24]) r_overflow <= 1'b1;
      end else begin
        r_cnt <= w_dec[23:0];
        if (w_dec[24]) r_done <= 1'b1;
      end
    end else if (w_run) begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Lap storage; write slot is the low bits of the count since laps fill in order.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int k = 0; k < LAP_DEPTH; k++) r_lap[k] <= 24'd0;
      r_lap_count <= {LCW{1'b0}};
      r_rd_ptr    <= {PTRW{1'b0}};
    end else if (i_clear) begin
      for (int k = 0; k < LAP_DEPTH; k++) r_lap[k] <= 24'd0;
      r_lap_count <= {LCW{1'b0}};
      r_rd_ptr    <= {PTRW{1'b0}};
    end else begin
      // r_cnt here is the pre-tick value when a tick lands in the same cycle.
      if (w_wr_rise && !w_lap_full) begin
        r_lap[r_lap_count[PTRW-1:0]] <= r_cnt;
        r_lap_count <= r_lap_count + 1'b1;
      end
      if (w_rd_rise && (r_lap_count != {LCW{1'b0}})) begin
        r_rd_ptr <= (w_rd_ext >= r_lap_count) ? {PTRW{1'b0}} : w_rd_ext[PTRW-1:0];
      end
    end
  end

  // Edge-detect history; only reset clears it so a held level never re-fires.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_hist <= 1'b0;
      r_rd_hist <= 1'b0;
    end else begin
      r_wr_hist <= i_write;
      r_rd_hist <= i_read;
    end
  end

  // Display source mux.
  always_comb begin
    o_digits = 16'h0000;
    case (i_output_select)
      2'b00:   o_digits = r_cnt[23:8];
      2'b01:   o_digits = r_cnt[15:0];
      2'b10:   o_digits = (r_lap_count == {LCW{1'b0}}) ? 16'h0000 : w_lap_sel[23:8];
      2'b11:   o_digits = (r_lap_count == {LCW{1'b0}}) ? 16'h0000 : w_lap_sel[15:0];
      default: o_digits = 16'h0000;
    endcase
  end

  assign o_done      = r_done;
  assign o_overflow  = r_overflow;
  assign o_lap_count = r_lap_count;
  assign o_lap_full  = w_lap_full;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper (TICK_DIV=4, LAP_DEPTH=4).
// Stimulus pushes expected output vectors; a negedge monitor pops and compares.
module tb_time_keeper;

  logic        clk;
  logic        nrst;
  logic        clear;
  logic        enable;
  logic        inc;
  logic        dec;
  logic        write;
  logic        read;
  logic [1:0]  sel;
  logic        load;
  logic [15:0] preset;
  logic [15:0] digits;
  logic        done;
  logic        overflow;
  logic [2:0]  lap_count;
  logic        lap_full;

  time_keeper #(.TICK_DIV(4), .LAP_DEPTH(4)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_clear(clear), .i_enable(enable),
    .i_enable_increment(inc), .i_enable_decrement(dec),
    .i_write(write), .i_read(read), .i_output_select(sel),
    .i_load(load), .i_preset(preset),
    .o_digits(digits), .o_done(done), .o_overflow(overflow),
    .o_lap_count(lap_count), .o_lap_full(lap_full)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic        dn;
    logic        ov;
    logic [2:0]  lc;
    logic        fl;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  exp_t  m_exp;
  exp_t  m_act;
  string m_nm;
  int    n_tests = 0;
  int    n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares one queued expectation per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_nm  = nm_q.pop_front();
      m_act = {digits, done, overflow, lap_count, lap_full};
      n_tests++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: got dig=%h done=%b ovf=%b lc=%0d full=%b, want dig=%h done=%b ovf=%b lc=%0d full=%b",
                 m_nm, m_act.dig, m_act.dn, m_act.ov, m_act.lc, m_act.fl,
                 m_exp.dig, m_exp.dn, m_exp.ov, m_exp.lc, m_exp.fl);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [1:0] s, input logic [15:0] d,
                     input logic dn, input logic ov, input logic [2:0] lc, input logic fl);
    exp_t e;
    sel = s;
    e = '{dig: d, dn: dn, ov: ov, lc: lc, fl: fl};
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] p);
    preset = p;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
  endtask

  task automatic pulse_write();
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; clear = 1'b0; enable = 1'b0; inc = 1'b0; dec = 1'b0;
    write = 1'b0; read = 1'b0; sel = 2'b00; load = 1'b0; preset = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel00", 2'b00, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // T1 up-count
    pulse_clear();
    inc = 1'b1;
    run(400);
    chk("t1_sel00", 2'b00, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("t1_sel01", 2'b01, 16'h0100, 1'b0, 1'b0, 3'd0, 1'b0);
    run(3);
    chk("t1_pre3_no_tick", 2'b01, 16'h0100, 1'b0, 1'b0, 3'd0, 1'b0);
    run(1);
    chk("t1_pre_tick", 2'b01, 16'h0101, 1'b0, 1'b0, 3'd0, 1'b0);

    // T2 up wrap
    do_load(16'h5959);
    chk("t2_load_sel00", 2'b00, 16'h5959, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("t2_load_sel01", 2'b01, 16'h5900, 1'b0, 1'b0, 3'd0, 1'b0);
    run(396);
    chk("t2_cs99", 2'b01, 16'h5999, 1'b0, 1'b0, 3'd0, 1'b0);
    run(4);
    chk("t2_wrap_sel00", 2'b00, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0);
    chk("t2_wrap_sel01", 2'b01, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0);
    do_load(16'hF9AF);
    chk("t2_saturate", 2'b00, 16'h5959, 1'b0, 1'b1, 3'd0, 1'b0);

    // T3 timer
    inc = 1'b0; dec = 1'b1;
    do_load(16'h0001);
    run(396);
    chk("t3_one_cs_left", 2'b01, 16'h0001, 1'b0, 1'b1, 3'd0, 1'b0);
    run(4);
    chk("t3_done", 2'b00, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0);
    run(40);
    chk("t3_hold_zero", 2'b01, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0);
    pulse_clear();
    chk("t3_clear", 2'b00, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);

    // T4 laps
    inc = 1'b1; dec = 1'b0;
    do_load(16'h1234);
    pulse_read();
    chk("t4_sel10_empty", 2'b10, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    write = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    write  = 1'b0;
    @(posedge clk); #1;
    chk("t4_live_after_tick", 2'b01, 16'h3401, 1'b0, 1'b0, 3'd1, 1'b0);
    chk("t4_lap0_sel10", 2'b10, 16'h1234, 1'b0, 1'b0, 3'd1, 1'b0);
    chk("t4_lap0_pretick", 2'b11, 16'h3400, 1'b0, 1'b0, 3'd1, 1'b0);
    do_load(16'h0510);
    write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    write = 1'b0;
    @(posedge clk); #1;
    chk("t4_held_write", 2'b00, 16'h0510, 1'b0, 1'b0, 3'd2, 1'b0);
    do_load(16'h5959);
    pulse_write();
    do_load(16'h0042);
    pulse_write();
    chk("t4_full", 2'b10, 16'h1234, 1'b0, 1'b0, 3'd4, 1'b1);
    do_load(16'h3333);
    pulse_write();
    chk("t4_fifth_ignored", 2'b00, 16'h3333, 1'b0, 1'b0, 3'd4, 1'b1);
    pulse_read();
    chk("t4_rd1", 2'b10, 16'h0510, 1'b0, 1'b0, 3'd4, 1'b1);
    pulse_read();
    chk("t4_rd2", 2'b10, 16'h5959, 1'b0, 1'b0, 3'd4, 1'b1);
    pulse_read();
    chk("t4_rd3", 2'b10, 16'h0042, 1'b0, 1'b0, 3'd4, 1'b1);
    pulse_read();
    chk("t4_rd0", 2'b10, 16'h1234, 1'b0, 1'b0, 3'd4, 1'b1);
    chk("t4_rd0_sel11", 2'b11, 16'h3400, 1'b0, 1'b0, 3'd4, 1'b1);

    // T5 conflicts
    pulse_clear();
    do_load(16'h0100);
    inc = 1'b1; dec = 1'b1;
    run(22);
    chk("t5_both_frozen", 2'b00, 16'h0100, 1'b0, 1'b0, 3'd0, 1'b0);
    dec = 1'b0;
    run(2);
    chk("t5_pre_held", 2'b01, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    run(2);
    chk("t5_tick_after", 2'b01, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b0);
    inc = 1'b0;
    run(8);
    chk("t5_neither_frozen", 2'b01, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b0);
    enable = 1'b1;
    preset = 16'h4444;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    enable = 1'b0;
    chk("t5_load_while_en", 2'b00, 16'h0100, 1'b0, 1'b0, 3'd0, 1'b0);
    clear = 1'b1;
    write = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    write = 1'b0;
    @(posedge clk); #1;
    chk("t5_clear_write", 2'b00, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);

    // T6 async reset
    dec = 1'b1;
    do_load(16'h0000);
    run(4);
    chk("t6_done_at_zero", 2'b00, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
    pulse_write();
    chk("t6_lap_stored", 2'b00, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b0);
    dec = 1'b0; inc = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    write = 1'b1;
    nrst  = 1'b0;
    chk("t6_reset_sel00", 2'b00, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("t6_reset_sel10", 2'b10, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    write  = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_after_release", 2'b01, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    run(3);
    chk("t6_pre_restart", 2'b01, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    run(1);
    chk("t6_first_tick", 2'b01, 16'h0001, 1'b0, 1'b0, 3'd0, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_not_drained: %0d expectations left", exp_q.size());
    end else begin
      $display("[TB] expectation queue drained");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL %0d mismatches", n_fail);
    end
    $finish;
  end

endmodule
